pipe_rr_arbiter: RTL and testbench
==================================

Name: pipe_rr_arbiter

Overview:
- Shares one outgoing PipeIn channel (16-bit method tag + 128-bit payload) between NREQ requester pipes, for example several M2P indication converters feeding a single host indication pipe.
- Each requester has a 2-entry input FIFO. A round-robin arbiter drains the FIFOs into one registered output stage.
- Payload words pass through unmodified.
- Sits between the M2P converters and the top-level indication pipe in generated tops.

Parameters:
- NREQ, 4, number of requester pipes (2..8).
- TAG_W, 16, method-tag width.
- DATA_W, 128, payload width.
- WIDTH, TAG_W+DATA_W, full pipe word width.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- req_enq__ENA  input  NREQ  per-requester enqueue strobe; bit i is asserted only when req_enq__RDY[i]=1.
- req_enq_v  input  NREQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
- req_enq__RDY  output  NREQ  per-requester ready; registered.
- out_enq__ENA  output  1  outgoing enqueue strobe.
- out_enq_v  output  WIDTH  outgoing word.
- out_enq__RDY  input  1  downstream ready.
- grant_last  output  clog2(NREQ)  index of the most recent grant (debug/status).

Behaviour:
- Reset, asynchronous, on nRST low:
  - all FIFO counts=0, so req_enq__RDY = all ones after reset release;
  - out_valid=0;
  - out_enq__ENA=0;
  - out_enq_v=0;
  - grant_last=NREQ-1, so requester 0 has first priority.
- A reset asserted mid-transfer discards all buffered words; no partial word is ever emitted.
- Transfer rule for any pipe: a word moves in the cycle where ENA=1 and RDY=1.
- Input FIFO i:
  - 2 entries, count 0..2;
  - req_enq__RDY[i] = (count_i < 2), taken from registered state only, with no combinational path from out_enq__RDY;
  - a write and a read in the same cycle leave count unchanged, and the order is preserved (FIFO);
  - an ENA while RDY=0 is a protocol violation, flagged by an assertion; the word is dropped.
- Output stage:
  - one register, out_valid plus out_word;
  - out_enq_v = out_word;
  - out_enq__ENA = out_valid & out_enq__RDY;
  - load_ok = !out_valid | out_enq__RDY, so back-to-back issue needs no bubble.
- Arbitration, evaluated every cycle:
  - candidates are FIFOs with count>0;
  - the search starts at (grant_last+1) mod NREQ and picks the first candidate in increasing index, wrapping;
  - if load_ok and a candidate exists, pop that FIFO head into the output register, set out_valid=1 and grant_last=winner;
  - otherwise, if out_enq__RDY, set out_valid=0.
- Latency: a word enqueued in cycle t, into an empty FIFO with the output stage free and no contention, appears with out_enq__ENA possible at t+2. That is one cycle in the FIFO and one in the output register.
- Throughput: one word per cycle aggregate; one word per cycle for a single active requester.
- Fairness: with all NREQ FIFOs continuously non-empty, the grant sequence is 0,1,..,NREQ-1,0,…, so no requester waits more than NREQ-1 grants.
- Downstream stall (out_enq__RDY=0): the output register holds its word stable, grant_last is frozen, and FIFOs fill to 2, then RDY drops.
- Simultaneous events:
  - a FIFO push and a pop of the same FIFO in one cycle is legal at count 1 or 2;
  - at count 0, a push is not visible to arbitration until the next cycle (no bypass).
- NREQ not a power of two: the wrap is computed mod NREQ, never into unused indices.

Decomposition:
- Package pipe_arb_pkg holds:
  - the localparam defaults TAG_W=16, DATA_W=128;
  - a pipe_word_t struct {tag, data};
  - the function rr_pick(req_mask, last) returning the winner index and a valid flag.
- One sub-module, pipe_fifo2, instantiated NREQ times: a 2-entry FIFO with registered not_full/not_empty.

Test Plan:
- Reset release, then a single word from requester 2 (tag 16'h0005, data 128'hA5…A5): out_enq__ENA at cycle +2 with identical word, and grant_last=2.
- All 4 requesters push each cycle, out_enq__RDY=1 for 16 cycles: output sequence of sources 0,1,2,3 repeating, 1 word/cycle, per-source order preserved.
- out_enq__RDY=0 for 10 cycles while requester 1 pushes: req_enq__RDY[1] falls after 2 accepted words plus the word held in the output register; out_enq_v stays stable; on RDY=1 the 3 words drain in order.
- Requester 3 alone streaming continuously: 1 word/cycle out, req_enq__RDY[3] stays 1.
- nRST pulsed low while FIFOs are full and out_valid=1: outputs zero asynchronously, all RDY=1 after release, and no stale word is emitted.
- Requesters 0 and 3 contend with grant_last=0: 3 wins, then 0, then 3 (wrap check).

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types and the round-robin pick function for the pipe arbiter.
package pipe_arb_pkg;

    localparam int unsigned TAG_W     = 16;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned NREQ_MAX  = 8;
    localparam int unsigned IDX_MAX_W = 3;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } pipe_word_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_mask searching upward from last+1, wrapping at nreq.
    function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0]  req_mask,
                                         input logic [IDX_MAX_W-1:0] last,
                                         input int unsigned          nreq);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
            idx = 32'(last) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k <= nreq && !res.valid && req_mask[idx[IDX_MAX_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = idx[IDX_MAX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_fifo2.sv
// Two-entry FIFO with registered not_full / not_empty flags.
// Latency: a pushed word is visible at the head one cycle later; pushes while full are dropped.
module pipe_fifo2 #(
    parameter int unsigned W = 144
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         not_full,
    output logic         not_empty,
    output logic [W-1:0] head_dat
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         not_full_q, not_full_d;
    logic         not_empty_q, not_empty_d;
    logic         push_ok, pop_ok;

    always_comb begin
        push_ok     = push & not_full_q;
        pop_ok      = pop & not_empty_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) rd_ptr_d = ~rd_ptr_q;
        count_d     = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        not_full_d  = (count_d != 2'd2);
        not_empty_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            not_full_q  <= 1'b1;
            not_empty_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            not_full_q  <= not_full_d;
            not_empty_q <= not_empty_d;
        end
    end

    assign not_full  = not_full_q;
    assign not_empty = not_empty_q;
    assign head_dat  = mem_q[rd_ptr_q];

    // Upstream must honour not_full; an offending word is dropped.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !not_full_q));

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin merge of NREQ requester pipes into one registered outgoing pipe.
// Latency 2 cycles (FIFO + output register); output register holds while out_enq__RDY=0, FIFOs then fill and drop RDY.
module pipe_rr_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned TAG_W  = pipe_arb_pkg::TAG_W,
    parameter int unsigned DATA_W = pipe_arb_pkg::DATA_W,
    parameter int unsigned WIDTH  = TAG_W + DATA_W
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREQ-1:0]         req_enq__ENA,
    input  logic [NREQ*WIDTH-1:0]   req_enq_v,
    output logic [NREQ-1:0]         req_enq__RDY,
    output logic                    out_enq__ENA,
    output logic [WIDTH-1:0]        out_enq_v,
    input  logic                    out_enq__RDY,
    output logic [$clog2(NREQ)-1:0] grant_last
);
    import pipe_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]      fifo_nf, fifo_ne, pop;
    logic [WIDTH-1:0]     head_dat [NREQ];

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_word_q, out_word_d;
    logic [IDX_W-1:0]     grant_last_q, grant_last_d;

    logic [NREQ_MAX-1:0]  cand_mask;
    logic [IDX_MAX_W-1:0] last_ext;
    rr_pick_t             pick;
    logic [IDX_W-1:0]     win_idx;
    logic                 load_ok;
    logic                 unused_pick_bits;

    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        pipe_fifo2 #(.W(WIDTH)) u_fifo (
            .clk       (CLK),
            .rst_n     (nRST),
            .push      (req_enq__ENA[g]),
            .push_dat  (req_enq_v[g*WIDTH +: WIDTH]),
            .pop       (pop[g]),
            .not_full  (fifo_nf[g]),
            .not_empty (fifo_ne[g]),
            .head_dat  (head_dat[g])
        );
    end

    always_comb begin
        cand_mask                = '0;
        cand_mask[NREQ-1:0]      = fifo_ne;
        last_ext                 = '0;
        last_ext[IDX_W-1:0]      = grant_last_q;
        pick                     = rr_pick(cand_mask, last_ext, NREQ);
        win_idx                  = pick.idx[IDX_W-1:0];
        load_ok                  = !out_valid_q | out_enq__RDY;

        pop          = '0;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        grant_last_d = grant_last_q;
        if (load_ok && pick.valid) begin
            pop[win_idx] = 1'b1;
            out_valid_d  = 1'b1;
            out_word_d   = head_dat[win_idx];
            grant_last_d = win_idx;
        end else if (out_enq__RDY) begin
            out_valid_d  = 1'b0;
        end
    end

    assign unused_pick_bits = &{1'b0, pick.idx};

    // Reset grant to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            grant_last_q <= IDX_W'(NREQ - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            grant_last_q <= grant_last_d;
        end
    end

    assign req_enq__RDY = fifo_nf;
    assign out_enq__ENA = out_valid_q & out_enq__RDY;
    assign out_enq_v    = out_word_q;
    assign grant_last   = grant_last_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter: latency, fairness, stall, streaming, reset, wrap.
module tb_pipe_rr_arbiter;
    import pipe_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 144;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NREQ-1:0]   req_enq__ENA;
    logic [NREQ*W-1:0] req_enq_v;
    logic [NREQ-1:0]   req_enq__RDY;
    logic              out_enq__ENA;
    logic [W-1:0]      out_enq_v;
    logic              out_enq__RDY;
    logic [1:0]        grant_last;

    int total = 0;
    int bad   = 0;

    pipe_rr_arbiter #(.NREQ(NREQ)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_enq__ENA (req_enq__ENA),
        .req_enq_v    (req_enq_v),
        .req_enq__RDY (req_enq__RDY),
        .out_enq__ENA (out_enq__ENA),
        .out_enq_v    (out_enq_v),
        .out_enq__RDY (out_enq__RDY),
        .grant_last   (grant_last)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] mkw(input int i, input int n);
        pipe_word_t w;
        w.tag  = 16'(i * 256 + n);
        w.data = {4{32'(32'h5A00_0000 + i * 4096 + n)}};
        return w;
    endfunction

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST         = 1'b0;
        req_enq__ENA = '0;
        req_enq_v    = '0;
        out_enq__RDY = 1'b1;
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int push_seq [NREQ];
        int out_seq  [NREQ];
        int exp_src;
        logic [W-1:0] t6_word [4];
        int           t6_gnt  [4];

        // Reset values and single-word latency from requester 2
        do_reset();
        @(negedge CLK);
        check_val("rst_rdy", req_enq__RDY, 4'hF);
        check_val("rst_ena", out_enq__ENA, 0);
        check_val("rst_v", out_enq_v, 0);
        check_val("rst_gnt", grant_last, 3);
        cyc();
        req_enq__ENA = 4'b0100;
        req_enq_v[2*W +: W] = {16'h0005, {16{8'hA5}}};
        @(negedge CLK);
        check_val("t1_ena_c0", out_enq__ENA, 0);
        cyc();
        req_enq__ENA = '0;
        @(negedge CLK);
        check_val("t1_ena_c1", out_enq__ENA, 0);
        cyc();
        @(negedge CLK);
        check_val("t1_ena_c2", out_enq__ENA, 1);
        check_val("t1_word", out_enq_v, {16'h0005, {16{8'hA5}}});
        check_val("t1_gnt", grant_last, 2);
        cyc();
        @(negedge CLK);
        check_val("t1_ena_c3", out_enq__ENA, 0);

        // All four requesters pushing: grants 0,1,2,3 repeating, 1 word/cycle
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push_seq[i] = 0;
            out_seq[i]  = 0;
        end
        exp_src = 0;
        for (int c = 0; c < 18; c++) begin
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                req_enq__ENA[i] = req_enq__RDY[i];
                if (req_enq__RDY[i]) begin
                    req_enq_v[i*W +: W] = mkw(i, push_seq[i]);
                    push_seq[i]++;
                end
            end
            @(negedge CLK);
            if (c >= 2) begin
                check_val("t2_ena", out_enq__ENA, 1);
                check_val("t2_word", out_enq_v, mkw(exp_src, out_seq[exp_src]));
                check_val("t2_gnt", grant_last, exp_src);
                out_seq[exp_src]++;
                exp_src = (exp_src + 1) % NREQ;
            end
        end
        req_enq__ENA = '0;

        // Downstream stall while requester 1 pushes
        do_reset();
        out_enq__RDY = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            req_enq__ENA = '0;
            if (req_enq__RDY[1]) begin
                req_enq__ENA[1] = 1'b1;
                req_enq_v[1*W +: W] = mkw(1, acc);
                acc++;
            end
            @(negedge CLK);
            if (c >= 2) begin
                check_val("t3_stall_ena", out_enq__ENA, 0);
                check_val("t3_stall_v", out_enq_v, mkw(1, 0));
            end
        end
        check_val("t3_accepted", W'(acc), 3);
        check_val("t3_rdy1", req_enq__RDY[1], 0);
        check_val("t3_gnt", grant_last, 1);
        cyc();
        req_enq__ENA = '0;
        out_enq__RDY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check_val("t3_drain_ena", out_enq__ENA, 1);
            check_val("t3_drain_v", out_enq_v, mkw(1, k));
            cyc();
        end
        @(negedge CLK);
        check_val("t3_drain_end", out_enq__ENA, 0);

        // Requester 3 streaming alone
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cyc();
            check_val("t4_rdy3", req_enq__RDY[3], 1);
            req_enq__ENA = 4'b1000;
            req_enq_v[3*W +: W] = mkw(3, c);
            @(negedge CLK);
            if (c >= 2) begin
                check_val("t4_ena", out_enq__ENA, 1);
                check_val("t4_word", out_enq_v, mkw(3, c - 2));
            end
        end
        cyc();
        req_enq__ENA = '0;

        // Reset pulse with FIFOs full and output register loaded
        do_reset();
        out_enq__RDY = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                req_enq__ENA[i] = req_enq__RDY[i];
                req_enq_v[i*W +: W] = mkw(i, 100 + c);
            end
        end
        cyc();
        req_enq__ENA = '0;
        @(negedge CLK);
        check_val("t5_full_rdy", req_enq__RDY, 4'h0);
        check_val("t5_held_v", out_enq_v, mkw(0, 100));
        cyc();
        out_enq__RDY = 1'b1;
        #1;
        check_val("t5_pre_ena", out_enq__ENA, 1);
        #1 nRST = 1'b0;
        #1;
        check_val("t5_async_ena", out_enq__ENA, 0);
        check_val("t5_async_v", out_enq_v, 0);
        check_val("t5_async_gnt", grant_last, 3);
        @(posedge CLK);
        #3 nRST = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            @(negedge CLK);
            check_val("t5_no_stale", out_enq__ENA, 0);
            check_val("t5_rdy", req_enq__RDY, 4'hF);
        end

        // Requesters 0 and 3 contend with grant_last=0: 3,0,3,0
        do_reset();
        cyc();
        req_enq__ENA = 4'b0001;
        req_enq_v[0 +: W] = mkw(0, 0);
        cyc();
        req_enq__ENA = '0;
        cyc();
        cyc();
        @(negedge CLK);
        check_val("t6_prime_gnt", grant_last, 0);
        check_val("t6_prime_ena", out_enq__ENA, 0);
        cyc();
        req_enq__ENA = 4'b1001;
        req_enq_v[0 +: W]   = mkw(0, 1);
        req_enq_v[3*W +: W] = mkw(3, 0);
        cyc();
        req_enq_v[0 +: W]   = mkw(0, 2);
        req_enq_v[3*W +: W] = mkw(3, 1);
        t6_word[0] = mkw(3, 0); t6_gnt[0] = 3;
        t6_word[1] = mkw(0, 1); t6_gnt[1] = 0;
        t6_word[2] = mkw(3, 1); t6_gnt[2] = 3;
        t6_word[3] = mkw(0, 2); t6_gnt[3] = 0;
        cyc();
        req_enq__ENA = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check_val("t6_ena", out_enq__ENA, 1);
            check_val("t6_word", out_enq_v, t6_word[k]);
            check_val("t6_gnt", grant_last, t6_gnt[k]);
            cyc();
        end
        @(negedge CLK);
        check_val("t6_end", out_enq__ENA, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
